// File: rtl/draw_pkg.sv
// draw_pkg: shared types and defaults for the drawing path blocks
// (sprite blitter, draw and iterator blocks).
//   blit_state_t     - sprite blitter FSM states
//   DEF_COLOUR_WIDTH - default pixel colour width
//   DEF_SCREEN_W/H   - default screen size used for clipping
//   clog2_min1()     - $clog2 that never returns 0, so 1-wide counters stay legal
package draw_pkg;

    localparam int DEF_COLOUR_WIDTH = 8;
    localparam int DEF_SCREEN_W     = 160;
    localparam int DEF_SCREEN_H     = 120;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } blit_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/blit_delay.sv
// blit_delay: STAGES-deep shift register carrying {valid, sx, sy} alongside
// the ROM read so the pixel coordinates line up with rom_q.
// Ports:
//   clk, resetn             - clock, synchronous active-low clear of every stage
//   valid_in, sx_in, sy_in  - tap pushed every cycle
//   valid_out, sx_out, sy_out - tap from STAGES cycles earlier
module blit_delay #(
    parameter int STAGES = 1,
    parameter int SX_W   = 4,
    parameter int SY_W   = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            valid_in,
    input  logic [SX_W-1:0] sx_in,
    input  logic [SY_W-1:0] sy_in,
    output logic            valid_out,
    output logic [SX_W-1:0] sx_out,
    output logic [SY_W-1:0] sy_out
);

    typedef struct packed {
        logic            valid;
        logic [SX_W-1:0] sx;
        logic [SY_W-1:0] sy;
    } tap_t;

    tap_t pipe [STAGES];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
        end else begin
            pipe[0].valid <= valid_in;
            pipe[0].sx    <= sx_in;
            pipe[0].sy    <= sy_in;
            for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign valid_out = pipe[STAGES-1].valid;
    assign sx_out    = pipe[STAGES-1].sx;
    assign sy_out    = pipe[STAGES-1].sy;

endmodule

// File: rtl/sprite_blit.sv
// sprite_blit: streams an SPR_W x SPR_H sprite from a synchronous ROM to the
// frame-buffer write port, one pixel per cycle, offset by (x_init, y_init),
// clipped to the screen, with optional colour-key transparency.
// Optional feature macro: SPRITE_MIRROR_EN adds a `mirror` input that flips
// the sprite horizontally (ROM column SPR_W-1-sx, x_out unchanged).
// Ports:
//   clk, resetn          - clock, synchronous active-low reset
//   start                - level request, sampled in IDLE; drop it to leave DONE
//   x_init, y_init       - sprite top-left, latched at start
//   key_en, key_colour   - transparency enable / colour, latched at start
//   mirror               - (SPRITE_MIRROR_EN only) horizontal flip, latched at start
//   rom_addr, rom_q      - sprite ROM address / data (ROM_LATENCY cycles later)
//   x_out, y_out, colour, write_en - frame-buffer write port
//   busy, done           - status (FETCH/DRAIN, DONE)
module sprite_blit import draw_pkg::*; #(
    parameter  int X_WIDTH      = 8,
    parameter  int Y_WIDTH      = 7,
    parameter  int SCREEN_W     = DEF_SCREEN_W,
    parameter  int SCREEN_H     = DEF_SCREEN_H,
    parameter  int SPR_W        = 16,
    parameter  int SPR_H        = 16,
    parameter  int COLOUR_WIDTH = DEF_COLOUR_WIDTH,
    parameter  int ROM_LATENCY  = 1,
    localparam int ADDR_WIDTH   = clog2_min1(SPR_W * SPR_H)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [X_WIDTH-1:0]      x_init,
    input  logic [Y_WIDTH-1:0]      y_init,
    input  logic                    key_en,
    input  logic [COLOUR_WIDTH-1:0] key_colour,
`ifdef SPRITE_MIRROR_EN
    input  logic                    mirror,
`endif
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    input  logic [COLOUR_WIDTH-1:0] rom_q,
    output logic [X_WIDTH-1:0]      x_out,
    output logic [Y_WIDTH-1:0]      y_out,
    output logic [COLOUR_WIDTH-1:0] colour,
    output logic                    write_en,
    output logic                    busy,
    output logic                    done
);

    localparam int SX_W = clog2_min1(SPR_W);
    localparam int SY_W = clog2_min1(SPR_H);

    localparam logic [SX_W-1:0]  SX_LAST    = SX_W'(SPR_W - 1);
    localparam logic [SY_W-1:0]  SY_LAST    = SY_W'(SPR_H - 1);
    localparam logic [1:0]       DRAIN_LAST = 2'(ROM_LATENCY - 1);
    localparam logic [X_WIDTH:0] SCR_W      = (X_WIDTH+1)'(SCREEN_W);
    localparam logic [Y_WIDTH:0] SCR_H      = (Y_WIDTH+1)'(SCREEN_H);

    blit_state_t             state;
    logic [SX_W-1:0]         sx;
    logic [SY_W-1:0]         sy;
    logic [1:0]              drain_cnt;
    logic [X_WIDTH-1:0]      x_lat;
    logic [Y_WIDTH-1:0]      y_lat;
    logic                    key_lat;
    logic [COLOUR_WIDTH-1:0] key_colour_lat;
`ifdef SPRITE_MIRROR_EN
    logic                    mirror_lat;
`endif

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= IDLE;
            sx             <= '0;
            sy             <= '0;
            drain_cnt      <= '0;
            x_lat          <= '0;
            y_lat          <= '0;
            key_lat        <= 1'b0;
            key_colour_lat <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
`ifdef SPRITE_MIRROR_EN
            mirror_lat     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_lat          <= x_init;
                        y_lat          <= y_init;
                        key_lat        <= key_en;
                        key_colour_lat <= key_colour;
`ifdef SPRITE_MIRROR_EN
                        mirror_lat     <= mirror;
`endif
                        sx             <= '0;
                        sy             <= '0;
                        busy           <= 1'b1;
                        state          <= FETCH;
                    end
                end
                FETCH: begin
                    if (sx == SX_LAST) begin
                        sx <= '0;
                        if (sy == SY_LAST) begin
                            sy        <= '0;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end else begin
                            sy <= sy + 1'b1;
                        end
                    end else begin
                        sx <= sx + 1'b1;
                    end
                end
                DRAIN: begin
                    // Let the last ROM_LATENCY reads reach the write port.
                    if (drain_cnt == DRAIN_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- ROM addressing ----------------
    logic [SX_W-1:0] col;
`ifdef SPRITE_MIRROR_EN
    assign col = mirror_lat ? (SX_LAST - sx) : sx;
`else
    assign col = sx;
`endif
    assign rom_addr = ADDR_WIDTH'(sy) * ADDR_WIDTH'(SPR_W) + ADDR_WIDTH'(col);

    // ---------------- coordinate delay line ----------------
    logic            valid_d;
    logic [SX_W-1:0] sx_d;
    logic [SY_W-1:0] sy_d;

    blit_delay #(
        .STAGES (ROM_LATENCY),
        .SX_W   (SX_W),
        .SY_W   (SY_W)
    ) u_delay (
        .clk       (clk),
        .resetn    (resetn),
        .valid_in  (state == FETCH),
        .sx_in     (sx),
        .sy_in     (sy),
        .valid_out (valid_d),
        .sx_out    (sx_d),
        .sy_out    (sy_d)
    );

    // ---------------- output stage ----------------
    // One extra bit so a sprite hanging off the right/bottom edge is clipped
    // rather than wrapping back onto the screen.
    logic [X_WIDTH:0] x_sum;
    logic [Y_WIDTH:0] y_sum;
    logic             on_screen;
    logic             keyed;

    assign x_sum     = (X_WIDTH+1)'(x_lat) + (X_WIDTH+1)'(sx_d);
    assign y_sum     = (Y_WIDTH+1)'(y_lat) + (Y_WIDTH+1)'(sy_d);
    assign on_screen = (x_sum < SCR_W) && (y_sum < SCR_H);
    assign keyed     = key_lat && (rom_q == key_colour_lat);

    assign write_en  = valid_d && on_screen && !keyed;
    assign x_out     = x_sum[X_WIDTH-1:0];
    assign y_out     = y_sum[Y_WIDTH-1:0];
    assign colour    = valid_d ? rom_q : '0;

endmodule

// File: tb/tb_sprite_blit.sv
module tb_sprite_blit;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       key_en = 1'b0;
    logic       mirror = 1'b0;
    logic [7:0] x_init = '0;
    logic [6:0] y_init = '0;
    logic [7:0] key_colour = '0;

    // index 0: ROM_LATENCY=1, index 1: ROM_LATENCY=3; both share stimulus
    logic [2:0] ra [2];
    logic [7:0] rq [2];
    logic [7:0] xo [2];
    logic [6:0] yo [2];
    logic [7:0] co [2];
    logic       we [2];
    logic       bz [2];
    logic       dn [2];

    int checks = 0;
    int errors = 0;

    int          nw [2];
    int          done_at [2];
    logic [31:0] we_mask [2];
    int          wx [2][16];
    int          wy [2][16];
    int          wc [2][16];

    always #5 clk = ~clk;

    // ROM holding its own address, latency 1 and latency 3
    logic [2:0] p3a, p3b;
    always @(posedge clk) rq[0] <= 8'(ra[0]);
    always @(posedge clk) begin
        p3a   <= ra[1];
        p3b   <= p3a;
        rq[1] <= 8'(p3b);
    end

    sprite_blit #(.SPR_W(4), .SPR_H(2), .ROM_LATENCY(1)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .x_init(x_init), .y_init(y_init), .key_en(key_en), .key_colour(key_colour),
`ifdef SPRITE_MIRROR_EN
        .mirror(mirror),
`endif
        .rom_addr(ra[0]), .rom_q(rq[0]),
        .x_out(xo[0]), .y_out(yo[0]), .colour(co[0]),
        .write_en(we[0]), .busy(bz[0]), .done(dn[0])
    );

    sprite_blit #(.SPR_W(4), .SPR_H(2), .ROM_LATENCY(3)) dut3 (
        .clk(clk), .resetn(resetn), .start(start),
        .x_init(x_init), .y_init(y_init), .key_en(key_en), .key_colour(key_colour),
`ifdef SPRITE_MIRROR_EN
        .mirror(mirror),
`endif
        .rom_addr(ra[1]), .rom_q(rq[1]),
        .x_out(xo[1]), .y_out(yo[1]), .colour(co[1]),
        .write_en(we[1]), .busy(bz[1]), .done(dn[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUTs idle. Start is sampled at the next
    // posedge (cycle 0); cycle k is the negedge after posedge k-1.
    task automatic draw(input int xi, input int yi, input int ke, input int kc, input int mi);
        x_init     = 8'(xi);
        y_init     = 7'(yi);
        key_en     = ke[0];
        key_colour = 8'(kc);
        mirror     = mi[0];
        start      = 1'b1;
        for (int d = 0; d < 2; d++) begin
            nw[d] = 0; done_at[d] = -1; we_mask[d] = '0;
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (k == 1) begin
                    check($sformatf("first_addr[%0d]", d), 32'(ra[d]), 0);
                    check($sformatf("busy_fetch[%0d]", d), 32'(bz[d]), 1);
                end
                if (we[d]) begin
                    we_mask[d][k] = 1'b1;
                    if (nw[d] < 16) begin
                        wx[d][nw[d]] = int'(xo[d]);
                        wy[d][nw[d]] = int'(yo[d]);
                        wc[d][nw[d]] = int'(co[d]);
                    end
                    nw[d]++;
                end
                if (dn[d] && done_at[d] < 0) done_at[d] = k;
            end
        end
        for (int d = 0; d < 2; d++) check($sformatf("done_held[%0d]", d), 32'(dn[d]), 1);
        start = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("idle_done[%0d]", d), 32'(dn[d]), 0);
            check($sformatf("idle_busy[%0d]", d), 32'(bz[d]), 0);
        end
    endtask

    // Full unclipped, unkeyed draw at (10,5): colours 0..7 in raster order.
    task automatic check_basic(input string name);
        logic [31:0] mask_exp [2];
        int          done_exp [2];
        mask_exp = '{32'h0000_03FC, 32'h0000_0FF0};
        done_exp = '{10, 12};
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_nw[%0d]", name, d), nw[d], 8);
            check($sformatf("%s_mask[%0d]", name, d), we_mask[d], mask_exp[d]);
            check($sformatf("%s_done[%0d]", name, d), done_at[d], done_exp[d]);
            for (int i = 0; i < 8; i++) begin
                check($sformatf("%s_x[%0d][%0d]", name, d, i), wx[d][i], 10 + i % 4);
                check($sformatf("%s_y[%0d][%0d]", name, d, i), wy[d][i], 5 + i / 4);
                check($sformatf("%s_c[%0d][%0d]", name, d, i), wc[d][i], i);
            end
        end
    endtask

    initial begin
        logic [31:0] key_mask [2];
        logic [31:0] clip_mask [2];
        int          done_exp [2];
        key_mask  = '{32'h0000_03DC, 32'h0000_0F70};
        clip_mask = '{32'h0000_000C, 32'h0000_0030};
        done_exp  = '{10, 12};

        // reset state
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_we[%0d]", d), 32'(we[d]), 0);
            check($sformatf("rst_busy[%0d]", d), 32'(bz[d]), 0);
            check($sformatf("rst_done[%0d]", d), 32'(dn[d]), 0);
            check($sformatf("rst_addr[%0d]", d), 32'(ra[d]), 0);
            check($sformatf("rst_x[%0d]", d), 32'(xo[d]), 0);
            check($sformatf("rst_y[%0d]", d), 32'(yo[d]), 0);
            check($sformatf("rst_c[%0d]", d), 32'(co[d]), 0);
        end
        resetn = 1'b1;
        @(negedge clk);

        // basic draw
        draw(10, 5, 0, 0, 0);
        check_basic("basic");

        // colour key 3: pixel 3 at (13,5) suppressed, timing unchanged
        draw(10, 5, 1, 3, 0);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("key_nw[%0d]", d), nw[d], 7);
            check($sformatf("key_mask[%0d]", d), we_mask[d], key_mask[d]);
            check($sformatf("key_done[%0d]", d), done_at[d], done_exp[d]);
            check($sformatf("key_x3[%0d]", d), wx[d][3], 10);
            check($sformatf("key_y3[%0d]", d), wy[d][3], 6);
            check($sformatf("key_c3[%0d]", d), wc[d][3], 4);
        end

        // clip at bottom-right corner: only (158,119) and (159,119)
        draw(158, 119, 0, 0, 0);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("clip_nw[%0d]", d), nw[d], 2);
            check($sformatf("clip_mask[%0d]", d), we_mask[d], clip_mask[d]);
            check($sformatf("clip_done[%0d]", d), done_at[d], done_exp[d]);
            check($sformatf("clip_x0[%0d]", d), wx[d][0], 158);
            check($sformatf("clip_x1[%0d]", d), wx[d][1], 159);
            check($sformatf("clip_y0[%0d]", d), wy[d][0], 119);
            check($sformatf("clip_y1[%0d]", d), wy[d][1], 119);
            check($sformatf("clip_c0[%0d]", d), wc[d][0], 0);
            check($sformatf("clip_c1[%0d]", d), wc[d][1], 1);
        end

        // reset mid-draw, just before pixel 3 is written by the latency-1 DUT
        x_init = 8'd10; y_init = 7'd5; key_en = 1'b0; mirror = 1'b0;
        start  = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_we_before", 32'(we[0]), 1);
        resetn = 1'b0;
        start  = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("mid_we[%0d]", d), 32'(we[d]), 0);
            check($sformatf("mid_busy[%0d]", d), 32'(bz[d]), 0);
            check($sformatf("mid_done[%0d]", d), 32'(dn[d]), 0);
        end
        resetn = 1'b1;
        nw[0] = 0; nw[1] = 0;
        repeat (6) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) if (we[d]) nw[d]++;
        end
        for (int d = 0; d < 2; d++) check($sformatf("mid_quiet[%0d]", d), nw[d], 0);

        // restart after reset: full draw again
        draw(10, 5, 0, 0, 0);
        check_basic("restart");

`ifdef SPRITE_MIRROR_EN
        draw(10, 5, 0, 0, 1);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("mir_nw[%0d]", d), nw[d], 8);
            for (int i = 0; i < 8; i++) begin
                check($sformatf("mir_x[%0d][%0d]", d, i), wx[d][i], 10 + i % 4);
                check($sformatf("mir_c[%0d][%0d]", d, i), wc[d][i], (i / 4) * 4 + 3 - i % 4);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_blit.md
Name: sprite_blit

Overview:
- Parametrised sprite blitter for the VGA-adapter drawing path.
- On `start`, it streams an SPR_W x SPR_H image from an external synchronous ROM to the frame-buffer write port at one pixel per cycle.
- Output coordinates are offset by (x_init, y_init). Pixels are clipped to the screen, and an optional colour key makes pixels transparent.
- Sits between the game FSM (start/done handshake) and the VGA adapter (x/y/colour/write_en).

Parameters:
- X_WIDTH, 8, screen x coordinate width
- Y_WIDTH, 7, screen y coordinate width
- SCREEN_W, 160, screen width in pixels; clip bound
- SCREEN_H, 120, screen height in pixels; clip bound
- SPR_W, 16, sprite width, 1..SCREEN_W
- SPR_H, 16, sprite height, 1..SCREEN_H
- COLOUR_WIDTH, 8, pixel colour width
- ROM_LATENCY, 1, ROM read latency in cycles, 1..4
- ADDR_WIDTH (localparam), $clog2(SPR_W*SPR_H), ROM address width

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- start  in  1  level request; sampled in IDLE
- x_init  in  X_WIDTH  sprite top-left x; latched at start
- y_init  in  Y_WIDTH  sprite top-left y; latched at start
- key_en  in  1  enable transparency; latched at start
- key_colour  in  COLOUR_WIDTH  transparent colour; latched at start
- rom_addr  out  ADDR_WIDTH  ROM address, = sy*SPR_W + sx
- rom_q  in  COLOUR_WIDTH  ROM data, valid ROM_LATENCY cycles after rom_addr
- x_out  out  X_WIDTH  pixel x
- y_out  out  Y_WIDTH  pixel y
- colour  out  COLOUR_WIDTH  pixel colour (= rom_q aligned)
- write_en  out  1  frame-buffer write strobe
- busy  out  1  high in FETCH and DRAIN
- done  out  1  high in DONE

Behaviour:
- Reset: resetn is synchronous, active-low; clk is the clock.
  - On reset: state=IDLE, sprite counters sx/sy=0, rom_addr=0.
  - All pipeline valid bits clear, so write_en=0, busy=0, done=0.
  - x_out/y_out/colour are 0.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - start=1 latches x_init, y_init, key_en and key_colour, clears sx/sy, and moves to FETCH.
- FETCH:
  - Drives rom_addr for (sx,sy) every cycle and pushes valid=1 plus (sx,sy) into a ROM_LATENCY-deep delay line.
  - sx increments; at SPR_W-1, sx wraps to 0 and sy increments.
  - After issuing (SPR_W-1, SPR_H-1), moves to DRAIN.
- DRAIN:
  - Pushes valid=0 for ROM_LATENCY cycles, then moves to DONE.
- DONE:
  - done=1 is held while start=1.
  - start=0 returns to IDLE (level handshake, same as the existing draw flow).
- Issue and write timing:
  - First rom_addr is issued the cycle after start is sampled.
  - The write for pixel n appears ROM_LATENCY cycles after its address.
  - Total cycles from start to done = SPR_W*SPR_H + ROM_LATENCY + 1.
- Output stage, per delayed pixel:
  - x_out = x_lat + sx_d and y_out = y_lat + sy_d, truncated to port width.
  - Clip test is computed at width+1 bits: x_lat+sx_d < SCREEN_W and y_lat+sy_d < SCREEN_H.
  - write_en = valid_d & on_screen & ~(key_lat & rom_q==key_colour_lat).
  - Clipped and keyed pixels still take their cycle; they are never compressed out.
- start while busy or DONE: ignored; latched operands are unchanged.
- Reset mid-operation: returns to IDLE next edge and clears all valid bits; no further write_en.
- SPR_W*SPR_H must be < 2^ADDR_WIDTH+1; no address wrap is possible.

Optional Feature:
- Macro SPRITE_MIRROR_EN.
- When defined:
  - Adds input port `mirror` (1 bit), latched at start.
  - When latched mirror=1, rom_addr uses column SPR_W-1-sx; x_out is unchanged, giving a horizontally flipped image.
  - Clipping and keying are applied after the flip.
- When undefined: no port, and addressing is always sy*SPR_W+sx.

Decomposition:
- Package draw_pkg:
  - blit_state_t enum (IDLE, FETCH, DRAIN, DONE).
  - COLOUR_WIDTH default.
  - Default SCREEN_W/SCREEN_H constants shared with the existing draw and iterator blocks.
- One sub-module, blit_delay: a parametrised ROM_LATENCY-stage shift register carrying {valid, sx, sy}, with synchronous clear on reset.

Test Plan:
- Basic draw (SPR_W=4, SPR_H=2, ROM_LATENCY=1, ROM holds the address value, x_init=10, y_init=5, key_en=0) -> 8 consecutive write_en pulses.
  - Coordinates (10,5)..(13,5),(10,6)..(13,6); colours 0..7.
  - done 10 cycles after start.
- Colour key (same setup, key_en=1, key_colour=3) -> 7 writes; the (13,5) cycle has write_en=0; done timing unchanged.
- Clip (x_init=158, y_init=119) -> writes only at (158,119) and (159,119); no write with wrapped x.
- ROM_LATENCY=3 -> first write_en exactly 3 cycles after the first rom_addr; colour matches the address issued 3 cycles earlier; done at cycle 12.
- Handshake (start held high) -> done stays 1; dropping start gives IDLE next cycle; re-raising start issues a second full draw.
- Reset mid-draw: resetn=0 at pixel 3 -> write_en=0 from the next cycle, busy=0, done=0; restart draws all 8 pixels.
- With SPRITE_MIRROR_EN and mirror=1 -> row 0 colours are 3,2,1,0 at x=10..13.
